// File: rtl/csr_trap_unit_mw_if.sv
// MW-stage control and redirect bundle between the pipeline and the CSR/trap unit.
// The pipeline side is the master; the CSR/trap unit is the slave.
interface csr_trap_unit_mw_if;
    logic        stall_mw;
    logic        valid_mw;
    logic        csr_reg_rd_mw;
    logic        csr_reg_wr_mw;
    logic        is_mret_mw;
    logic [2:0]  funct3_mw;
    logic [11:0] csr_addr_mw;
    logic [31:0] rs1_data_mw;
    logic [4:0]  zimm_mw;
    logic [31:0] next_pc_mw;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_pc;

    modport master (
        output stall_mw, valid_mw, csr_reg_rd_mw, csr_reg_wr_mw, is_mret_mw,
               funct3_mw, csr_addr_mw, rs1_data_mw, zimm_mw, next_pc_mw,
               timer_irq, ext_irq,
        input  csr_rdata, epc_taken, epc_pc
    );

    modport slave (
        input  stall_mw, valid_mw, csr_reg_rd_mw, csr_reg_wr_mw, is_mret_mw,
               funct3_mw, csr_addr_mw, rs1_data_mw, zimm_mw, next_pc_mw,
               timer_irq, ext_irq,
        output csr_rdata, epc_taken, epc_pc
    );
endinterface

// File: rtl/csr_trap_unit_mw.sv
// Machine-mode CSR file and trap/interrupt sequencer for the MW stage.
// Executes Zicsr read-modify-writes, takes interrupts at commit and issues a one-cycle redirect.
module csr_trap_unit_mw #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_trap_unit_mw_if.slave    bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic        mip_mtip_q, mip_mtip_d;
    logic        mip_meip_q, mip_meip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        epc_taken_q, epc_taken_d;
    logic [31:0] epc_pc_q, epc_pc_d;

    logic [31:0] old_val;
    logic [31:0] src_val;
    logic [31:0] wr_val;
    logic        wr_ok;
    logic        commit;
    logic        irq_pend;
    logic        ext_hit;
    logic        take_mret;
    logic        take_irq;
    logic        csr_wr_en;
    logic [4:0]  cause_code;
    logic [31:0] vec_base;
    logic [31:0] trap_target;

    always_comb begin
        old_val = '0;
        case (bus.csr_addr_mw)
            ADDR_MSTATUS: begin
                old_val[3] = mstatus_mie_q;
                old_val[7] = mstatus_mpie_q;
            end
            ADDR_MIE: begin
                old_val[7]  = mie_mtie_q;
                old_val[11] = mie_meie_q;
            end
            ADDR_MTVEC:  old_val = mtvec_q;
            ADDR_MEPC:   old_val = mepc_q;
            ADDR_MCAUSE: old_val = mcause_q;
            ADDR_MIP: begin
                old_val[7]  = mip_mtip_q;
                old_val[11] = mip_meip_q;
            end
            default:     old_val = '0;
        endcase
    end

    assign bus.csr_rdata = bus.csr_reg_rd_mw ? old_val : '0;

    // Set/clear forms with a zero source are pure reads and must not write.
    always_comb begin
        src_val = bus.funct3_mw[2] ? {27'b0, bus.zimm_mw} : bus.rs1_data_mw;
        wr_val  = src_val;
        wr_ok   = 1'b0;
        case (bus.funct3_mw[1:0])
            2'b01: begin wr_val = src_val;            wr_ok = 1'b1;     end
            2'b10: begin wr_val = old_val | src_val;  wr_ok = |src_val; end
            2'b11: begin wr_val = old_val & ~src_val; wr_ok = |src_val; end
            default: begin wr_val = src_val;          wr_ok = 1'b0;     end
        endcase
    end

    assign commit    = bus.valid_mw & ~bus.stall_mw & ~epc_taken_q;
    assign ext_hit   = mie_meie_q & mip_meip_q;
    assign irq_pend  = mstatus_mie_q & (ext_hit | (mie_mtie_q & mip_mtip_q));
    assign take_mret = commit & bus.is_mret_mw;
    assign take_irq  = commit & ~bus.is_mret_mw & irq_pend;
    assign csr_wr_en = commit & ~bus.is_mret_mw & bus.csr_reg_wr_mw & wr_ok;

    // The vector target uses the mtvec value in force before this commit's write.
    assign cause_code  = ext_hit ? 5'd11 : 5'd7;
    assign vec_base    = {mtvec_q[31:2], 2'b00};
    assign trap_target = (VECTORED_EN && (mtvec_q[1:0] == 2'b01))
                         ? vec_base + {25'b0, cause_code, 2'b00} : vec_base;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mip_mtip_d     = bus.timer_irq;
        mip_meip_d     = bus.ext_irq;

        if (csr_wr_en) begin
            case (bus.csr_addr_mw)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                ADDR_MIE: begin
                    mie_mtie_d = wr_val[7];
                    mie_meie_d = wr_val[11];
                end
                ADDR_MTVEC:  mtvec_d  = {wr_val[31:2], 1'b0, wr_val[0]};
                ADDR_MEPC:   mepc_d   = {wr_val[31:2], 2'b00};
                ADDR_MCAUSE: mcause_d = wr_val;
                default: ;
            endcase
        end

        // Trap and MRET state changes take precedence over the instruction's own write.
        if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (take_irq) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = {bus.next_pc_mw[31:2], 2'b00};
            mcause_d       = {1'b1, 26'b0, cause_code};
        end

        epc_taken_d = bus.stall_mw ? epc_taken_q : (take_mret | take_irq);
        if (take_mret) begin
            epc_pc_d = mepc_q;
        end else if (take_irq) begin
            epc_pc_d = trap_target;
        end else begin
            epc_pc_d = epc_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            epc_taken_q    <= 1'b0;
            epc_pc_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mip_mtip_q     <= mip_mtip_d;
            mip_meip_q     <= mip_meip_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            epc_taken_q    <= epc_taken_d;
            epc_pc_q       <= epc_pc_d;
        end
    end

    assign bus.epc_taken = epc_taken_q;
    assign bus.epc_pc    = epc_pc_q;
endmodule

// File: tb/tb_csr_trap_unit_mw.sv
// Bench for csr_trap_unit_mw: vector table, directed trap/MRET/stall sequences and
// randomized traffic compared against a behavioural CSR/trap model.
module tb_csr_trap_unit_mw;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam bit          VEC_EN    = 1'b1;

    logic clk;
    logic rst;
    csr_trap_unit_mw_if bus();

    csr_trap_unit_mw #(.MTVEC_RESET(MTVEC_RST), .VECTORED_EN(VEC_EN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit mchk    = 1'b0;

    // Model state: CSR values kept as full 32-bit words with their architectural masks.
    logic [31:0] m_status = 32'h0, m_mie = 32'h0, m_mip = 32'h0;
    logic [31:0] m_tvec = MTVEC_RST, m_mepc = 32'h0, m_mcause = 32'h0, m_epc = 32'h0;
    bit          m_etk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_status;
            12'h304: return m_mie;
            12'h305: return m_tvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] old, src, nv, pre_status, pre_tvec, base, mip_n, code;
        bit wen, commit, pend, ext_hit;
        mip_n = (bus.ext_irq ? 32'h800 : 32'h0) | (bus.timer_irq ? 32'h80 : 32'h0);
        if (rst) begin
            m_status = 0; m_mie = 0; m_mip = 0; m_tvec = MTVEC_RST;
            m_mepc = 0; m_mcause = 0; m_etk = 0; m_epc = 0;
            return;
        end
        if (bus.stall_mw) begin
            m_mip = mip_n;
            return;
        end
        old        = m_read(bus.csr_addr_mw);
        src        = bus.funct3_mw[2] ? {27'd0, bus.zimm_mw} : bus.rs1_data_mw;
        commit     = bus.valid_mw && !m_etk;
        pend       = m_status[3] && ((m_mie & m_mip & 32'h880) != 0);
        ext_hit    = (m_mie & m_mip & 32'h800) != 0;
        pre_status = m_status;
        pre_tvec   = m_tvec;
        m_etk      = 1'b0;
        if (commit && bus.is_mret_mw) begin
            m_status = (pre_status[7] ? 32'h8 : 32'h0) | 32'h80;
            m_epc    = m_mepc;
            m_etk    = 1'b1;
        end else if (commit) begin
            wen = 1'b0;
            nv  = 32'h0;
            case (bus.funct3_mw)
                3'd1, 3'd5: begin nv = src;        wen = 1'b1;       end
                3'd2, 3'd6: begin nv = old | src;  wen = (src != 0); end
                3'd3, 3'd7: begin nv = old & ~src; wen = (src != 0); end
                default: ;
            endcase
            if (bus.csr_reg_wr_mw && wen) begin
                case (bus.csr_addr_mw)
                    12'h300: m_status = nv & 32'h88;
                    12'h304: m_mie    = nv & 32'h880;
                    12'h305: m_tvec   = nv & ~32'h2;
                    12'h341: m_mepc   = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
            if (pend) begin
                code     = ext_hit ? 32'd11 : 32'd7;
                m_status = pre_status[3] ? 32'h80 : 32'h0;
                m_mepc   = bus.next_pc_mw & ~32'h3;
                m_mcause = 32'h8000_0000 | code;
                base     = pre_tvec & ~32'h3;
                m_epc    = (VEC_EN && pre_tvec[1:0] == 2'b01) ? base + code * 4 : base;
                m_etk    = 1'b1;
            end
        end
        m_mip = mip_n;
    endtask

    // First half of a cycle: outputs settled at the falling edge, compared with the model.
    task automatic half1();
        @(negedge clk);
        if (mchk) begin
            chk("model_rdata", bus.csr_rdata, bus.csr_reg_rd_mw ? m_read(bus.csr_addr_mw) : 32'h0);
            chk("model_epc_taken", {31'd0, bus.epc_taken}, {31'd0, m_etk});
            if (m_etk) chk("model_epc_pc", bus.epc_pc, m_epc);
        end
    endtask

    task automatic half2();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run();
        half1();
        half2();
    endtask

    task automatic idle();
        bus.valid_mw = 0; bus.csr_reg_rd_mw = 0; bus.csr_reg_wr_mw = 0; bus.is_mret_mw = 0;
        bus.funct3_mw = 3'd0; bus.csr_addr_mw = 12'h0; bus.rs1_data_mw = 0; bus.zimm_mw = 0;
    endtask

    task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r, input logic [4:0] z);
        bus.valid_mw = 1; bus.csr_reg_rd_mw = 1; bus.csr_reg_wr_mw = 1; bus.is_mret_mw = 0;
        bus.funct3_mw = f3; bus.csr_addr_mw = a; bus.rs1_data_mw = r; bus.zimm_mw = z;
    endtask

    task automatic plain_instr(input logic [31:0] npc);
        idle();
        bus.valid_mw = 1;
        bus.next_pc_mw = npc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        bus.stall_mw = 0; bus.timer_irq = 0; bus.ext_irq = 0; bus.next_pc_mw = 0;
        run();
        run();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];
    logic [2:0]  f3_pool[8]    = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4};
    logic [11:0] addr_pool[7]  = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
    logic [31:0] rs1_pool[6]   = '{32'h0, 32'h8, 32'h88, 32'h80, 32'h800, 32'h880};
    logic [11:0] rd_addrs[6]   = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    logic [31:0] rd_exp[6]     = '{32'h0, 32'h0, MTVEC_RST, 32'h0, 32'h0, 32'h0};

    initial begin
        tbl[0]  = '{3'b010, 12'h305, 32'h0,        5'd0,  1'b1, 32'h0000_0100};
        tbl[1]  = '{3'b010, 12'h305, 32'h0,        5'd0,  1'b1, 32'h0000_0100};
        tbl[2]  = '{3'b001, 12'h304, 32'h880,      5'd0,  1'b1, 32'h0000_0000};
        tbl[3]  = '{3'b111, 12'h304, 32'h0,        5'd0,  1'b1, 32'h0000_0880};
        tbl[4]  = '{3'b010, 12'h304, 32'h0,        5'd0,  1'b1, 32'h0000_0880};
        tbl[5]  = '{3'b001, 12'h304, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0000_0880};
        tbl[6]  = '{3'b011, 12'h304, 32'h80,       5'd0,  1'b1, 32'h0000_0880};
        tbl[7]  = '{3'b010, 12'h304, 32'h80,       5'd0,  1'b1, 32'h0000_0800};
        tbl[8]  = '{3'b001, 12'h305, 32'h203,      5'd0,  1'b1, 32'h0000_0100};
        tbl[9]  = '{3'b010, 12'h305, 32'h0,        5'd0,  1'b1, 32'h0000_0201};
        tbl[10] = '{3'b001, 12'h341, 32'h107,      5'd0,  1'b1, 32'h0000_0000};
        tbl[11] = '{3'b110, 12'h341, 32'h0,        5'd3,  1'b1, 32'h0000_0104};
        tbl[12] = '{3'b010, 12'h341, 32'h0,        5'd0,  1'b1, 32'h0000_0104};
        tbl[13] = '{3'b001, 12'h342, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h0000_0000};
        tbl[14] = '{3'b111, 12'h342, 32'h0,        5'hF,  1'b1, 32'hDEAD_BEEF};
        tbl[15] = '{3'b010, 12'h342, 32'h0,        5'd0,  1'b1, 32'hDEAD_BEE0};
        tbl[16] = '{3'b001, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0000_0000};
        tbl[17] = '{3'b010, 12'h300, 32'h0,        5'd0,  1'b1, 32'h0000_0088};
        tbl[18] = '{3'b001, 12'h344, 32'hFFFF,     5'd0,  1'b1, 32'h0000_0000};
        tbl[19] = '{3'b010, 12'h344, 32'h0,        5'd0,  1'b1, 32'h0000_0000};
        tbl[20] = '{3'b001, 12'h7C0, 32'h5,        5'd0,  1'b1, 32'h0000_0000};
        tbl[21] = '{3'b010, 12'h7C0, 32'h0,        5'd0,  1'b1, 32'h0000_0000};
        tbl[22] = '{3'b011, 12'h300, 32'hFF,       5'd0,  1'b1, 32'h0000_0088};
        tbl[23] = '{3'b010, 12'h300, 32'h0,        5'd0,  1'b0, 32'h0000_0000};

        do_reset();
        mchk = 1'b1;
        half1();
        chk("reset_epc_taken", {31'd0, bus.epc_taken}, 32'd0);
        chk("reset_epc_pc", bus.epc_pc, 32'd0);
        half2();

        for (int i = 0; i < 24; i++) begin
            op(tbl[i].f3, tbl[i].addr, tbl[i].rs1, tbl[i].zimm);
            bus.csr_reg_rd_mw = tbl[i].rd;
            half1();
            chk($sformatf("tbl%0d_rdata", i), bus.csr_rdata, tbl[i].exp);
            half2();
        end

        // Timer trap into a vectored mtvec.
        do_reset();
        op(3'b001, 12'h304, 32'h80, 5'd0);  run();
        op(3'b001, 12'h305, 32'h201, 5'd0); run();
        op(3'b001, 12'h300, 32'h8, 5'd0);   run();
        idle(); bus.timer_irq = 1;          run();
        plain_instr(32'h104);               run();
        op(3'b010, 12'h342, 32'h0, 5'd0);
        half1();
        chk("vec_epc_taken", {31'd0, bus.epc_taken}, 32'd1);
        chk("vec_epc_pc", bus.epc_pc, 32'h21C);
        chk("vec_mcause", bus.csr_rdata, 32'h8000_0007);
        half2();
        bus.timer_irq = 0;
        op(3'b010, 12'h341, 32'h0, 5'd0);
        half1();
        chk("vec_pulse_end", {31'd0, bus.epc_taken}, 32'd0);
        chk("vec_mepc", bus.csr_rdata, 32'h104);
        half2();
        op(3'b010, 12'h300, 32'h0, 5'd0);
        half1(); chk("vec_mstatus", bus.csr_rdata, 32'h80); half2();

        // External beats timer, direct mode, then MRET back to mepc.
        op(3'b001, 12'h305, 32'h200, 5'd0); run();
        op(3'b001, 12'h304, 32'h880, 5'd0); run();
        idle(); bus.timer_irq = 1; bus.ext_irq = 1; run();
        op(3'b001, 12'h300, 32'h8, 5'd0);   run();
        plain_instr(32'h300);               run();
        op(3'b010, 12'h342, 32'h0, 5'd0);
        half1();
        chk("ext_epc_taken", {31'd0, bus.epc_taken}, 32'd1);
        chk("ext_epc_pc", bus.epc_pc, 32'h200);
        chk("ext_mcause", bus.csr_rdata, 32'h8000_000B);
        half2();
        bus.timer_irq = 0; bus.ext_irq = 0;
        op(3'b001, 12'h341, 32'h104, 5'd0); run();
        idle(); bus.valid_mw = 1; bus.is_mret_mw = 1; run();
        op(3'b010, 12'h300, 32'h0, 5'd0);
        half1();
        chk("mret_epc_taken", {31'd0, bus.epc_taken}, 32'd1);
        chk("mret_epc_pc", bus.epc_pc, 32'h104);
        chk("mret_mstatus", bus.csr_rdata, 32'h88);
        half2();

        // Stall holds off a pending interrupt.
        idle(); bus.timer_irq = 1; run();
        op(3'b001, 12'h305, 32'h200, 5'd0);
        bus.stall_mw = 1;
        for (int i = 0; i < 3; i++) begin
            half1();
            chk("stall_no_trap", {31'd0, bus.epc_taken}, 32'd0);
            chk("stall_mtvec", bus.csr_rdata, 32'h200);
            half2();
        end
        bus.stall_mw = 0;
        run();
        op(3'b010, 12'h342, 32'h0, 5'd0);
        half1();
        chk("unstall_epc_taken", {31'd0, bus.epc_taken}, 32'd1);
        chk("unstall_epc_pc", bus.epc_pc, 32'h200);
        chk("unstall_mcause", bus.csr_rdata, 32'h8000_0007);
        half2();
        bus.timer_irq = 0;

        // mstatus write in the trap cycle loses to the trap.
        op(3'b001, 12'h300, 32'h8, 5'd0); run();
        idle(); bus.timer_irq = 1; run();
        op(3'b001, 12'h300, 32'h0, 5'd0); bus.next_pc_mw = 32'h400; run();
        idle();
        half1(); chk("race_pulse", {31'd0, bus.epc_taken}, 32'd1); half2();
        op(3'b010, 12'h300, 32'h0, 5'd0);
        half1();
        chk("race_pulse_once", {31'd0, bus.epc_taken}, 32'd0);
        chk("race_mstatus", bus.csr_rdata, 32'h80);
        half2();
        op(3'b010, 12'h341, 32'h0, 5'd0);
        half1(); chk("race_mepc", bus.csr_rdata, 32'h400); half2();

        // Reset in the trap commit cycle drops the redirect.
        op(3'b001, 12'h300, 32'h8, 5'd0); run();
        plain_instr(32'h500); rst = 1; run();
        rst = 0; bus.timer_irq = 0; idle();
        half1();
        chk("rst_drop_taken", {31'd0, bus.epc_taken}, 32'd0);
        chk("rst_drop_pc", bus.epc_pc, 32'd0);
        half2();
        for (int i = 0; i < 6; i++) begin
            idle(); bus.valid_mw = 1; bus.csr_reg_rd_mw = 1;
            bus.funct3_mw = 3'b010; bus.csr_addr_mw = rd_addrs[i];
            half1();
            chk($sformatf("reset_val_%h", rd_addrs[i]), bus.csr_rdata, rd_exp[i]);
            half2();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.valid_mw      = ($urandom_range(0, 3) != 0);
            bus.stall_mw      = ($urandom_range(0, 4) == 0);
            bus.csr_reg_rd_mw = 1'($urandom_range(0, 1));
            bus.csr_reg_wr_mw = 1'($urandom_range(0, 1));
            bus.is_mret_mw    = ($urandom_range(0, 15) == 0);
            bus.funct3_mw     = f3_pool[$urandom_range(0, 7)];
            bus.csr_addr_mw   = addr_pool[$urandom_range(0, 6)];
            bus.rs1_data_mw   = ($urandom_range(0, 1) != 0) ? rs1_pool[$urandom_range(0, 5)] : $urandom;
            bus.zimm_mw       = 5'($urandom_range(0, 31));
            bus.next_pc_mw    = $urandom;
            if ($urandom_range(0, 7) == 0) bus.timer_irq = ~bus.timer_irq;
            if ($urandom_range(0, 9) == 0) bus.ext_irq = ~bus.ext_irq;
            run();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
